// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus issue/result registers feeding an external combinational ALU.
// Optional accumulator operand path enabled by defining ALU_ACC_EN.
module alu_cmd_issuer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic [1:0]       i_cmd_op,
  input  logic             i_cmd_acc,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_overflow,
  input  logic             i_alu_zero,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_overflow,
  output logic             o_res_zero,
  output logic             o_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t           r_state;
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_memA [DEPTH];
  logic [WIDTH-1:0] r_memB [DEPTH];
  logic [1:0]       r_memOp [DEPTH];
  logic [WIDTH-1:0] r_issA;
  logic [WIDTH-1:0] r_issB;
  logic [1:0]       r_issOp;
  logic [WIDTH-1:0] r_resData;
  logic             r_resOverflow;
  logic             r_resZero;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_issValid;
  logic w_resValid;
  logic w_cap;
  logic w_load;
  logic w_issNext;
  logic w_resNext;

  // Full when the index bits match but the wrap bits differ.
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_push  = i_cmd_valid && !w_full;

  assign w_issValid = (r_state == ST_EXEC) || (r_state == ST_FULL);
  assign w_resValid = (r_state == ST_HOLD) || (r_state == ST_FULL);
  assign w_cap      = w_issValid && (!w_resValid || i_res_ready);
  assign w_load     = !w_empty && (!w_issValid || w_cap);
  assign w_issNext  = w_load || (w_issValid && !w_cap);
  assign w_resNext  = w_cap || (w_resValid && !i_res_ready);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memA[r_wrPtr[AW-1:0]]  <= i_cmd_a;
      r_memB[r_wrPtr[AW-1:0]]  <= i_cmd_b;
      r_memOp[r_wrPtr[AW-1:0]] <= i_cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_load) r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

`ifdef ALU_ACC_EN
  logic             r_memAcc [DEPTH];
  logic             r_issAcc;
  logic [WIDTH-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (w_push) r_memAcc[r_wrPtr[AW-1:0]] <= i_cmd_acc;
  end

  // The accumulator updates on the same edge the next command issues, so
  // back-to-back accumulate commands chain without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issAcc <= 1'b0;
      r_acc    <= '0;
    end else begin
      if (w_load) r_issAcc <= r_memAcc[r_rdPtr[AW-1:0]];
      if (w_cap)  r_acc    <= i_alu_result;
    end
  end

  assign o_alu_a = r_issAcc ? r_acc : r_issA;
`else
  logic w_unusedAcc;
  assign w_unusedAcc = i_cmd_acc;
  assign o_alu_a     = r_issA;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_EMPTY;
      r_issA        <= '0;
      r_issB        <= '0;
      r_issOp       <= '0;
      r_resData     <= '0;
      r_resOverflow <= 1'b0;
      r_resZero     <= 1'b0;
    end else begin
      unique case ({w_resNext, w_issNext})
        2'b00:   r_state <= ST_EMPTY;
        2'b01:   r_state <= ST_EXEC;
        2'b10:   r_state <= ST_HOLD;
        default: r_state <= ST_FULL;
      endcase
      if (w_load) begin
        r_issA  <= r_memA[r_rdPtr[AW-1:0]];
        r_issB  <= r_memB[r_rdPtr[AW-1:0]];
        r_issOp <= r_memOp[r_rdPtr[AW-1:0]];
      end
      if (w_cap) begin
        r_resData     <= i_alu_result;
        r_resOverflow <= i_alu_overflow;
        r_resZero     <= i_alu_zero;
      end
    end
  end

  assign o_cmd_ready    = !w_full;
  assign o_alu_b        = r_issB;
  assign o_alu_op       = r_issOp;
  assign o_res_valid    = w_resValid;
  assign o_res_data     = r_resData;
  assign o_res_overflow = r_resOverflow;
  assign o_res_zero     = r_resZero;
  assign o_busy         = !w_empty || w_issValid || w_resValid;

endmodule
